msgpass_buff_writer: RTL and testbench
======================================

Name: msgpass_buff_writer

Overview:
Write-side controller for the message-pass buffer. Accepts per-row access-request vectors (one request address plus one valid flag per share-group lane) over a valid/ready stream. Packs each vector into one buffer page and writes a burst of pages into buffer write port A, starting at a programmable base address. It is the producer of the page layout that the buffer read-address generator and memShare control consume: each lane occupies its low RQST_ADDR_BITWIDTH bits as address and its MSB as the valid flag.

Parameters:
SHARE_GROUP_SIZE, 5, number of lanes per page
RQST_ADDR_BITWIDTH, 2, request address width per lane
LANE_WIDTH, RQST_ADDR_BITWIDTH+1, per-lane field width (derived)
BUFF_DEPTH, 16, buffer pages
BUFF_ADDR_WIDTH, $clog2(BUFF_DEPTH), page address width (derived)
BUFF_DATA_WIDTH, SHARE_GROUP_SIZE*LANE_WIDTH, page width (derived)

Ports:
sys_clk  in  1  system clock
rst  in  1  synchronous reset, active-high
start_i  in  1  burst start pulse, sampled in IDLE only
abort_i  in  1  abort the current burst
base_addr_i  in  BUFF_ADDR_WIDTH  first page address of the burst
page_num_i  in  BUFF_ADDR_WIDTH+1  pages in the burst, range 0..BUFF_DEPTH
rqst_valid_i  in  1  request vector valid
rqst_ready_o  out  1  request vector accepted when valid and ready
rqst_addr_i  in  SHARE_GROUP_SIZE*RQST_ADDR_BITWIDTH  packed lane addresses, lane i at [(i+1)*A-1:i*A]
rqst_mask_i  in  SHARE_GROUP_SIZE  per-lane valid flag
waddr_portA_o  out  BUFF_ADDR_WIDTH  buffer write address
wdata_portA_o  out  BUFF_DATA_WIDTH  buffer write data
wen_portA_o  out  1  buffer write enable, active LOW
busy_o  out  1  burst in progress
done_o  out  1  one-cycle pulse at burst completion
err_o  out  1  one-cycle pulse when a burst is rejected
wr_count_o  out  BUFF_ADDR_WIDTH+1  pages written in the current or last burst

Behaviour:
- Reset state: IDLE. wen_portA_o=1; waddr/wdata=0; rqst_ready_o, busy_o, done_o, err_o=0; wr_count_o=0.
- Reset during a burst: any pending write is suppressed. wen_portA_o is 1 from the reset edge onward.
- FSM states: IDLE, WRITE, DONE.
- IDLE:
  - start_i with page_num_i=0: done_o pulses the next cycle; state stays IDLE.
  - start_i with a valid range: latch base_addr_i and page_num_i, clear wr_count_o, go to WRITE. busy_o=1 from the next cycle.
  - start_i with an invalid range: see Optional Feature.
- WRITE:
  - rqst_ready_o = (state==WRITE) && !abort_i. This is combinational on abort_i.
  - Each handshake registers one write. In the next cycle: wen_portA_o=0, waddr_portA_o = current pointer, and wdata lane i = {mask[i], mask[i] ? addr_i : 0}. Latency is 1 cycle.
  - After each handshake: pointer+1, wr_count_o+1.
  - Cycles without a handshake: wen_portA_o=1; waddr and wdata hold their last values.
  - Handshake on the final page: next state is DONE.
  - start_i is ignored while in WRITE.
- DONE (one cycle): done_o=1, coincident with the final wen_portA_o=0 cycle. busy_o=0 from the following cycle; return to IDLE.
- abort_i in WRITE: the beat presented in that cycle is not accepted. Next state IDLE, no done_o. Any write registered in the previous cycle still completes. wr_count_o holds.
- abort_i outside WRITE: no effect.
- Simultaneous start_i and abort_i in IDLE: start_i wins.

Optional Feature:
MSGPASS_WR_ADDR_WRAP_EN
- Defined: the page pointer wraps modulo BUFF_DEPTH, so base_addr_i+page_num_i > BUFF_DEPTH is accepted. page_num_i > BUFF_DEPTH is still rejected with err_o.
- Undefined: base_addr_i+page_num_i > BUFF_DEPTH is rejected at start. err_o pulses the next cycle, the state stays IDLE, and no write is issued.

Test Plan:
1. base=0, page_num=4, valid held high for 4 beats -> wen_portA_o low on 4 consecutive cycles starting one cycle after the first handshake; waddr 0,1,2,3; done_o coincides with waddr=3; wr_count_o=4.
2. Lane addresses {lane4..lane0}={2,0,1,2,3}, mask=5'b10101 -> wdata_portA_o=15'h6147.
3. Valid pattern 1,0,1,1,0,1 with page_num=4 -> wen_portA_o high in the gap cycles; waddr holds during gaps and ends at 3; no duplicate writes.
4. base=14, page_num=4 -> without macro: err_o pulses once, no write occurs. With macro: waddr 14,15,0,1, then done_o.
5. page_num=5, abort_i after 2 handshakes -> exactly 2 writes (0,1); no done_o; busy_o falls; wr_count_o=2.
6. rst asserted mid-burst after 1 beat, then page_num=0 start -> wen_portA_o=1 immediately after the reset edge and all outputs at reset values; the zero-length start yields a done_o pulse with no write.

Source files
------------

// File: rtl/msgpass_buff_writer_if.sv
// Request-vector stream and buffer write port A of the message-pass buffer writer.
// Signal names carry their direction as seen from the writer (slave modport).
interface msgpass_buff_writer_if #(
  parameter int SHARE_GROUP_SIZE   = 5,
  parameter int RQST_ADDR_BITWIDTH = 2,
  parameter int BUFF_DEPTH         = 16
);
  localparam int LANE_WIDTH      = RQST_ADDR_BITWIDTH + 1;
  localparam int BUFF_ADDR_WIDTH = $clog2(BUFF_DEPTH);
  localparam int BUFF_DATA_WIDTH = SHARE_GROUP_SIZE * LANE_WIDTH;

  logic                                       rqst_valid_i;
  logic                                       rqst_ready_o;
  logic [SHARE_GROUP_SIZE*RQST_ADDR_BITWIDTH-1:0] rqst_addr_i;
  logic [SHARE_GROUP_SIZE-1:0]                rqst_mask_i;
  logic [BUFF_ADDR_WIDTH-1:0]                 waddr_portA_o;
  logic [BUFF_DATA_WIDTH-1:0]                 wdata_portA_o;
  logic                                       wen_portA_o;

  modport master (
    output rqst_valid_i, rqst_addr_i, rqst_mask_i,
    input  rqst_ready_o, waddr_portA_o, wdata_portA_o, wen_portA_o
  );

  modport slave (
    input  rqst_valid_i, rqst_addr_i, rqst_mask_i,
    output rqst_ready_o, waddr_portA_o, wdata_portA_o, wen_portA_o
  );
endinterface

// File: rtl/msgpass_buff_writer.sv
// Message-pass buffer writer: packs request vectors into pages and bursts them into port A.
// Optional macro MSGPASS_WR_ADDR_WRAP_EN lets a burst wrap the page pointer modulo BUFF_DEPTH.
module msgpass_buff_writer #(
  parameter int SHARE_GROUP_SIZE   = 5,
  parameter int RQST_ADDR_BITWIDTH = 2,
  parameter int LANE_WIDTH         = RQST_ADDR_BITWIDTH + 1,
  parameter int BUFF_DEPTH         = 16,
  parameter int BUFF_ADDR_WIDTH    = $clog2(BUFF_DEPTH),
  parameter int BUFF_DATA_WIDTH    = SHARE_GROUP_SIZE * LANE_WIDTH
) (
  input  logic                       sys_clk,
  input  logic                       rst,
  input  logic                       start_i,
  input  logic                       abort_i,
  input  logic [BUFF_ADDR_WIDTH-1:0] base_addr_i,
  input  logic [BUFF_ADDR_WIDTH:0]   page_num_i,
  msgpass_buff_writer_if.slave       bus,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       err_o,
  output logic [BUFF_ADDR_WIDTH:0]   wr_count_o
);

  localparam int CNT_WIDTH  = BUFF_ADDR_WIDTH + 1;
  localparam int RQST_WIDTH = SHARE_GROUP_SIZE * RQST_ADDR_BITWIDTH;
  localparam logic [CNT_WIDTH-1:0]       DEPTH_CNT = CNT_WIDTH'(BUFF_DEPTH);
  localparam logic [BUFF_ADDR_WIDTH-1:0] LAST_PAGE = BUFF_ADDR_WIDTH'(BUFF_DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [BUFF_ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [CNT_WIDTH-1:0]       pages_q, pages_d;
  logic [CNT_WIDTH-1:0]       wr_count_q, wr_count_d;
  logic                       wen_q, wen_d;
  logic [BUFF_ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [BUFF_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       err_q, err_d;

  logic                       rqst_ready_s;
  logic                       handshake_s;
  logic                       last_page_s;
  logic                       page_num_zero_s;
  logic                       range_bad_s;
  logic [BUFF_ADDR_WIDTH-1:0] ptr_inc_s;
  logic [BUFF_DATA_WIDTH-1:0] page_s;

  // Lane i = {valid, addr}; a masked-off lane is written as all zeros so readers see a clean page.
  function automatic logic [BUFF_DATA_WIDTH-1:0] pack_page(
    input logic [RQST_WIDTH-1:0]       addr,
    input logic [SHARE_GROUP_SIZE-1:0] mask
  );
    logic [BUFF_DATA_WIDTH-1:0] page;
    page = '0;
    for (int i = 0; i < SHARE_GROUP_SIZE; i++) begin
      page[i*LANE_WIDTH +: LANE_WIDTH] =
        {mask[i], (mask[i] ? addr[i*RQST_ADDR_BITWIDTH +: RQST_ADDR_BITWIDTH]
                           : {RQST_ADDR_BITWIDTH{1'b0}})};
    end
    return page;
  endfunction

`ifdef MSGPASS_WR_ADDR_WRAP_EN
  // Wrapping bursts are legal; only a burst longer than the buffer is refused.
  always_comb begin
    range_bad_s = (page_num_i > DEPTH_CNT);
  end
`else
  localparam int SUM_WIDTH = BUFF_ADDR_WIDTH + 2;
  localparam logic [SUM_WIDTH-1:0] DEPTH_SUM = SUM_WIDTH'(BUFF_DEPTH);
  logic [SUM_WIDTH-1:0] range_end_s;

  // The burst must fit between base and the top of the buffer.
  always_comb begin
    range_end_s = SUM_WIDTH'(base_addr_i) + SUM_WIDTH'(page_num_i);
    range_bad_s = (page_num_i > DEPTH_CNT) || (range_end_s > DEPTH_SUM);
  end
`endif

  assign page_num_zero_s = (page_num_i == '0);
  assign rqst_ready_s    = (state_q == ST_WRITE) && !abort_i;
  assign handshake_s     = bus.rqst_valid_i && rqst_ready_s;
  assign last_page_s     = ((wr_count_q + CNT_WIDTH'(1)) == pages_q);
  assign ptr_inc_s       = (ptr_q == LAST_PAGE) ? '0 : (ptr_q + BUFF_ADDR_WIDTH'(1));
  assign page_s          = pack_page(bus.rqst_addr_i, bus.rqst_mask_i);

  // Next-state and registered-output logic; write strobe defaults to idle every cycle.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    pages_d    = pages_q;
    wr_count_d = wr_count_q;
    wen_d      = 1'b1;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (page_num_zero_s) begin
            done_d = 1'b1;
          end else if (range_bad_s) begin
            err_d = 1'b1;
          end else begin
            state_d    = ST_WRITE;
            ptr_d      = base_addr_i;
            pages_d    = page_num_i;
            wr_count_d = '0;
            busy_d     = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_WRITE: begin
        // Abort drops ready in the same cycle, so no beat can slip through with it.
        if (abort_i) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else if (handshake_s) begin
          wen_d      = 1'b0;
          waddr_d    = ptr_q;
          wdata_d    = page_s;
          ptr_d      = ptr_inc_s;
          wr_count_d = wr_count_q + CNT_WIDTH'(1);
          if (last_page_s) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_WRITE;
          end
        end else begin
          state_d = ST_WRITE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset; reset kills any write in flight.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      pages_q    <= '0;
      wr_count_q <= '0;
      wen_q      <= 1'b1;
      waddr_q    <= '0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      pages_q    <= pages_d;
      wr_count_q <= wr_count_d;
      wen_q      <= wen_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bus.rqst_ready_o  = rqst_ready_s;
  assign bus.waddr_portA_o = waddr_q;
  assign bus.wdata_portA_o = wdata_q;
  assign bus.wen_portA_o   = wen_q;
  assign busy_o            = busy_q;
  assign done_o            = done_q;
  assign err_o             = err_q;
  assign wr_count_o        = wr_count_q;

endmodule

// File: tb/tb_msgpass_buff_writer.sv
// Scoreboard bench for msgpass_buff_writer: directed plan bursts followed by random bursts.
module tb_msgpass_buff_writer;

  localparam int SG    = 5;
  localparam int AW    = 2;
  localparam int LW    = AW + 1;
  localparam int DEPTH = 16;
  localparam int BAW   = $clog2(DEPTH);

  logic           sys_clk = 1'b0;
  logic           rst     = 1'b1;
  logic           start_i = 1'b0;
  logic           abort_i = 1'b0;
  logic [BAW-1:0] base_addr_i = '0;
  logic [BAW:0]   page_num_i  = '0;
  logic           busy_o, done_o, err_o;
  logic [BAW:0]   wr_count_o;

  always #5 sys_clk = ~sys_clk;

  msgpass_buff_writer_if #(.SHARE_GROUP_SIZE(SG), .RQST_ADDR_BITWIDTH(AW), .BUFF_DEPTH(DEPTH)) bus();

  msgpass_buff_writer #(.SHARE_GROUP_SIZE(SG), .RQST_ADDR_BITWIDTH(AW), .BUFF_DEPTH(DEPTH)) dut (
    .sys_clk     (sys_clk),
    .rst         (rst),
    .start_i     (start_i),
    .abort_i     (abort_i),
    .base_addr_i (base_addr_i),
    .page_num_i  (page_num_i),
    .bus         (bus),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .wr_count_o  (wr_count_o)
  );

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  typedef enum int {M_IDLE, M_WRITE, M_DONE} mst_t;
  mst_t m_st = M_IDLE;
  int   m_ptr = 0;
  int   m_cnt = 0;

  typedef struct {int cyc; int addr; int data;} wr_t;
  wr_t exp_wr[$];
  bit  exp_done[int];
  bit  exp_err[int];

  bit fix_en   = 1'b0;
  int fix_addr = 0;
  int fix_mask = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference page: each valid lane contributes (2^AW + addr) at its lane offset.
  function automatic int model_page(input int addr_bits, input int mask_bits);
    int v = 0;
    for (int i = 0; i < SG; i++) begin
      if (((mask_bits >> i) & 1) != 0)
        v += ((1 << AW) + ((addr_bits >> (AW * i)) % (1 << AW))) << (LW * i);
    end
    return v;
  endfunction

  function automatic bit range_ok(input int b, input int n);
`ifdef MSGPASS_WR_ADDR_WRAP_EN
    return n <= DEPTH;
`else
    return (n <= DEPTH) && (b + n <= DEPTH);
`endif
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic set_data();
    if (fix_en) begin
      bus.rqst_addr_i = (SG*AW)'(fix_addr);
      bus.rqst_mask_i = SG'(fix_mask);
    end else begin
      bus.rqst_addr_i = (SG*AW)'($urandom());
      bus.rqst_mask_i = SG'($urandom());
    end
  endtask

  task automatic check_window();
    #1;
    chk("rqst_ready", bus.rqst_ready_o, (m_st == M_WRITE) && !abort_i);
    chk("busy", busy_o, m_st != M_IDLE);
  endtask

  task automatic run_burst(input int base, input int n, input logic [31:0] vpat, input int vlen,
                           input int vpct, input int abort_at, input bit abort_on_start, input int rst_at);
    bit started;
    bit did_rst;
    bit v;
    int w;
    started = 1'b0;
    did_rst = 1'b0;
    start_i = 1'b1;
    base_addr_i = BAW'(base);
    page_num_i  = (BAW+1)'(n);
    abort_i = abort_on_start;
    bus.rqst_valid_i = 1'($urandom_range(0, 1));
    set_data();
    check_window();
    if (n == 0) exp_done[cyc + 1] = 1'b1;
    else if (!range_ok(base, n)) exp_err[cyc + 1] = 1'b1;
    else begin
      m_st = M_WRITE; m_ptr = base; m_cnt = 0; started = 1'b1;
    end
    tick();
    start_i = 1'b0;
    abort_i = 1'b0;
    w = 0;
    while (m_st == M_WRITE && w < 300) begin
      if (w < vlen) v = vpat[w];
      else v = ($urandom_range(0, 99) < vpct);
      abort_i = (m_cnt == abort_at);
      rst = (m_cnt == rst_at);
      if (rst) v = 1'b1;
      bus.rqst_valid_i = v;
      set_data();
      check_window();
      if (rst) begin
        m_st = M_IDLE; m_cnt = 0; did_rst = 1'b1;
      end else if (abort_i) begin
        m_st = M_IDLE;
      end else if (v) begin
        exp_wr.push_back('{cyc + 1, m_ptr,
                           model_page(int'(bus.rqst_addr_i), int'(bus.rqst_mask_i))});
        m_ptr = (m_ptr + 1) % DEPTH;
        m_cnt++;
        if (m_cnt == n) begin
          exp_done[cyc + 1] = 1'b1;
          m_st = M_DONE;
        end
      end
      tick();
      w++;
    end
    rst = 1'b0;
    abort_i = 1'b0;
    bus.rqst_valid_i = 1'b0;
    if (m_st == M_WRITE) begin
      n_checks++;
      $display("FAIL burst_budget: still writing after %0d cycles, required completion", w);
      abort_i = 1'b1; tick(); abort_i = 1'b0; m_st = M_IDLE;
    end
    if (did_rst) begin
      chk("rst_waddr", bus.waddr_portA_o, 0);
      chk("rst_wdata", bus.wdata_portA_o, 0);
      chk("rst_wen", bus.wen_portA_o, 1);
      chk("rst_done", done_o, 0);
      chk("rst_err", err_o, 0);
    end
    if (m_st == M_DONE) begin
      check_window();
      m_st = M_IDLE;
      tick();
    end
    check_window();
    if (started) chk("wr_count", wr_count_o, m_cnt);
    tick();
  endtask

  // Scoreboard monitor: pops an expected write whenever port A strobes, and checks pulses.
  wr_t mw;
  always @(negedge sys_clk) begin
    chk("done_o", done_o, exp_done.exists(cyc));
    chk("err_o", err_o, exp_err.exists(cyc));
    if (bus.wen_portA_o === 1'b0) begin
      if (exp_wr.size() == 0) begin
        chk("spurious_write", exp_wr.size(), 1);
      end else begin
        mw = exp_wr.pop_front();
        chk("write_cycle", cyc, mw.cyc);
        chk("waddr", bus.waddr_portA_o, mw.addr);
        chk("wdata", bus.wdata_portA_o, mw.data);
      end
    end else if (exp_wr.size() != 0 && exp_wr[0].cyc <= cyc) begin
      chk("wen_low", bus.wen_portA_o, 0);
      mw = exp_wr.pop_front();
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, required $finish");
    $fatal(1);
  end

  initial begin
    int b;
    int n;
    int ab;
    bus.rqst_valid_i = 1'b0;
    bus.rqst_addr_i  = '0;
    bus.rqst_mask_i  = '0;
    repeat (3) tick();
    chk("reset_wen", bus.wen_portA_o, 1);
    chk("reset_waddr", bus.waddr_portA_o, 0);
    chk("reset_wdata", bus.wdata_portA_o, 0);
    chk("reset_wr_count", wr_count_o, 0);
    rst = 1'b0;
    check_window();
    tick();

    run_burst(0, 4, 32'h0, 0, 100, -1, 1'b0, -1);
    fix_en = 1'b1; fix_addr = 'h21B; fix_mask = 'b10101;
    run_burst(5, 1, 32'h0, 0, 100, -1, 1'b0, -1);
    fix_en = 1'b0;
    run_burst(0, 4, 32'b101101, 6, 100, -1, 1'b0, -1);
    run_burst(14, 4, 32'h0, 0, 100, -1, 1'b0, -1);
    run_burst(0, 5, 32'h0, 0, 100, 2, 1'b0, -1);
    run_burst(0, 5, 32'h0, 0, 100, -1, 1'b0, 1);
    run_burst(3, 0, 32'h0, 0, 100, -1, 1'b0, -1);
    run_burst(0, 16, 32'h0, 0, 80, -1, 1'b0, -1);
    run_burst(1, 16, 32'h0, 0, 100, -1, 1'b0, -1);
    run_burst(0, 17, 32'h0, 0, 100, -1, 1'b0, -1);
    run_burst(2, 3, 32'h0, 0, 100, -1, 1'b1, -1);
    run_burst(7, 3, 32'h0, 0, 100, 0, 1'b0, -1);

    repeat (50) begin
      b  = $urandom_range(0, DEPTH - 1);
      n  = $urandom_range(0, DEPTH + 2);
      ab = ($urandom_range(0, 7) == 0) ? $urandom_range(0, (n > 0) ? n - 1 : 0) : -1;
      run_burst(b, n, 32'h0, 0, $urandom_range(40, 100), ab, $urandom_range(0, 4) == 0, -1);
    end

    repeat (3) tick();
    chk("exp_wr_drained", exp_wr.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
